axis_sample_framer: RTL and testbench
=====================================

Name: axis_sample_framer

Overview:
- Upstream stage feeding the 4096-deep AXI-stream sample FIFO.
- Takes a free-running, non-backpressurable sample stream (ADC-style: valid with no ready) and clamps each sample to a signed ±MAX_VALUE range.
- Groups accepted samples into fixed-length frames, with m_last on the final beat of each frame.
- Presents the result on an AXI-stream master port through a 2-entry buffer, counting samples dropped when that buffer is full.

Parameters:
- DataWidth, 16, sample width (two's complement).
- MAX_VALUE, 2048, clamp bound: output range is [-MAX_VALUE, MAX_VALUE-1].
- FRAME_LEN, 8, accepted samples per frame (>=2).
- NUM_FRAMES, 0, frames per run before auto-stop; 0 = unlimited.
- CntWidth, 16, width of drop_count and frame_count.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse: begin a run (honoured only in IDLE).
- stop  in  1  one-cycle pulse: end run after the current frame (honoured only in RUN).
- in_valid  in  1  sample present this cycle; no backpressure.
- in_data  in  DataWidth  signed sample.
- m_data  out  DataWidth  clamped sample.
- m_valid  out  1  AXI-stream valid.
- m_ready  in  1  AXI-stream ready (from FIFO s_ready).
- m_last  out  1  final beat of a frame.
- busy  out  1  high whenever state != IDLE.
- drop_count  out  CntWidth  samples lost to a full buffer, saturating.
- frame_count  out  CntWidth  frames completed in this run (wraps modulo 2^CntWidth).

Behaviour:
- Reset (clk, rst synchronous active-high): state=IDLE, buffer emptied, beat_cnt=0. Outputs m_valid=0, m_last=0, m_data=0, busy=0, drop_count=0, frame_count=0. Reset mid-run discards buffered beats; m_valid is low the cycle after rst.
- States:
  - IDLE: start -> RUN. On the start edge, drop_count, frame_count and beat_cnt clear. The sample on the start cycle is not accepted.
  - RUN: accepts samples. stop with beat_cnt==0 -> FLUSH. stop with beat_cnt!=0 -> STOP_PEND. Completing frame NUM_FRAMES (NUM_FRAMES!=0) -> FLUSH.
  - STOP_PEND: keeps accepting until the last beat of the current frame is pushed -> FLUSH.
  - FLUSH: accepts nothing; waits for buffer count==0 -> IDLE.
- start outside IDLE and stop outside RUN are ignored. start and stop in the same IDLE cycle: start honoured.
- Accept rule (RUN/STOP_PEND): in_valid && count<2, where count is registered (no combinational path from m_ready). If in_valid && count==2, the sample is dropped; drop_count increments, saturating at all-ones. beat_cnt is not advanced by drops.
- Clamp:
  - in_data < -MAX_VALUE -> -MAX_VALUE.
  - in_data > MAX_VALUE-1 -> MAX_VALUE-1.
  - Otherwise pass-through. Comparison is signed, full width.
- Framing:
  - The last flag is stored with the sample when beat_cnt==FRAME_LEN-1. beat_cnt then wraps to 0 and frame_count increments in the same cycle.
  - The NUM_FRAMES check uses the incremented value.
- Buffer: 2-entry FIFO of {data,last}; head drives m_data/m_last, and m_valid = count!=0.
  - Pop on m_valid && m_ready.
  - Simultaneous push and pop leaves count unchanged.
  - Latency: a sample accepted at cycle N is on m_data with m_valid=1 at cycle N+1 if the buffer was empty.
  - Full throughput with m_ready held high.
- AXI rule: while m_valid && !m_ready, m_data/m_last/m_valid hold stable.
- m_last is only asserted with m_valid; every run emits whole frames only.

Test Plan:
- Basic framing: FRAME_LEN=8, m_ready=1, start, then samples 1..16 on consecutive cycles -> 16 beats, each 1 cycle after input; m_last on values 8 and 16; frame_count=2; drop_count=0.
- Clamp: samples 0x7FFF, 0x8000, 2047, -2048, 2048, -2049 -> outputs 2047, -2048, 2047, -2048, 2047, -2048.
- Backpressure and drop: m_ready=0, 5 consecutive samples 10..14 -> 10,11 buffered and 12..14 dropped, drop_count=3, m_data held at 10. Then m_ready=1 -> 10,11 emitted; beat_cnt=2.
- Stop mid-frame: stop after 3 accepted beats -> busy stays high; 5 more samples accepted, m_last on the 8th; busy falls after the buffer drains; further in_valid is ignored and nothing is output.
- Auto-stop: NUM_FRAMES=2, 20 continuous samples -> exactly 16 beats out, frame_count=2, state IDLE, last 4 samples not counted as drops.
- Reset mid-run: rst with 2 beats buffered and m_ready=0 -> next cycle m_valid=0, counters 0, busy=0; a fresh start produces a new frame starting at beat 0.

Source files
------------

// File: rtl/axis_sample_framer.sv
// -----------------------------------------------------------------------------
// axis_sample_framer
//
// Front end for the 4096-deep AXI-stream sample FIFO. Samples arrive on a
// free-running ADC-style stream (valid, no ready). Each one is clamped to
// [-MAX_VALUE, MAX_VALUE-1] and grouped into frames of FRAME_LEN beats, with
// m_last marking the final beat. Samples go out through a 2-entry buffer.
// A sample that arrives while the buffer is full is dropped and counted.
//
// Ports
//   clk, rst      : clock, synchronous active-high reset
//   start         : pulse, begins a run (IDLE only)
//   stop          : pulse, ends the run after the current frame (RUN only)
//   in_valid      : sample present this cycle
//   in_data       : signed sample
//   m_data        : clamped sample at the buffer head
//   m_valid       : buffer not empty
//   m_ready       : downstream ready
//   m_last        : head beat closes a frame
//   busy          : run in progress (state != IDLE)
//   drop_count    : samples lost to a full buffer, saturating
//   frame_count   : frames completed in this run, wrapping
// -----------------------------------------------------------------------------
module axis_sample_framer #(
    parameter int DataWidth  = 16,
    parameter int MAX_VALUE  = 2048,
    parameter int FRAME_LEN  = 8,
    parameter int NUM_FRAMES = 0,
    parameter int CntWidth   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 in_valid,
    input  logic [DataWidth-1:0] in_data,
    output logic [DataWidth-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 m_last,
    output logic                 busy,
    output logic [CntWidth-1:0]  drop_count,
    output logic [CntWidth-1:0]  frame_count
);

    localparam int BeatW = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
    localparam logic [BeatW-1:0] LastBeat = BeatW'(FRAME_LEN - 1);
    localparam logic signed [DataWidth-1:0] ClampHi = DataWidth'(MAX_VALUE - 1);
    localparam logic signed [DataWidth-1:0] ClampLo = DataWidth'(-MAX_VALUE);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RUN       = 2'd1,
        ST_STOP_PEND = 2'd2,
        ST_FLUSH     = 2'd3
    } state_t;

    // Signed saturation of a raw sample into the output range.
    function automatic logic [DataWidth-1:0] clamp_sample(input logic [DataWidth-1:0] x);
        logic signed [DataWidth-1:0] xs;
        xs = $signed(x);
        if (xs < ClampLo) begin
            return ClampLo;
        end else if (xs > ClampHi) begin
            return ClampHi;
        end else begin
            return x;
        end
    endfunction

    state_t                 state_q, state_d;
    logic [BeatW-1:0]       beat_cnt_q, beat_cnt_d;
    logic [CntWidth-1:0]    frame_count_q, frame_count_d;
    logic [CntWidth-1:0]    drop_count_q, drop_count_d;
    logic [1:0]             count_q, count_d;
    logic [DataWidth-1:0]   head_data_q, head_data_d;
    logic [DataWidth-1:0]   tail_data_q, tail_data_d;
    logic                   head_last_q, head_last_d;
    logic                   tail_last_q, tail_last_d;
    logic                   m_valid_q;
    logic                   busy_q;

    logic                   start_s;
    logic                   push_s;
    logic                   drop_s;
    logic                   pop_s;
    logic                   last_s;
    logic                   frame_done_s;
    logic [DataWidth-1:0]   clamped_s;

    // State register plus all datapath registers (synchronous reset).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            beat_cnt_q    <= '0;
            frame_count_q <= '0;
            drop_count_q  <= '0;
            count_q       <= 2'd0;
            head_data_q   <= '0;
            head_last_q   <= 1'b0;
            tail_data_q   <= '0;
            tail_last_q   <= 1'b0;
            m_valid_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            beat_cnt_q    <= beat_cnt_d;
            frame_count_q <= frame_count_d;
            drop_count_q  <= drop_count_d;
            count_q       <= count_d;
            head_data_q   <= head_data_d;
            head_last_q   <= head_last_d;
            tail_data_q   <= tail_data_d;
            tail_last_q   <= tail_last_d;
            m_valid_q     <= (count_d != 2'd0);
            busy_q        <= (state_d != ST_IDLE);
        end
    end

    // Per-cycle strobes decoded from the current state and registered fill level.
    always_comb begin
        start_s   = 1'b0;
        push_s    = 1'b0;
        drop_s    = 1'b0;
        pop_s     = m_valid_q && m_ready;
        last_s    = (beat_cnt_q == LastBeat);
        clamped_s = clamp_sample(in_data);
        case (state_q)
            ST_IDLE: begin
                start_s = start;
            end
            ST_RUN, ST_STOP_PEND: begin
                // Acceptance looks only at the registered count, so m_ready
                // never reaches the accept decision combinationally.
                push_s = in_valid && (count_q != 2'd2);
                drop_s = in_valid && (count_q == 2'd2);
            end
            ST_FLUSH: begin
                start_s = 1'b0;
            end
            default: begin
                start_s = 1'b0;
            end
        endcase
        frame_done_s = push_s && last_s;
    end

    // Beat, frame and drop counters.
    always_comb begin
        beat_cnt_d    = beat_cnt_q;
        frame_count_d = frame_count_q;
        drop_count_d  = drop_count_q;
        if (start_s) begin
            beat_cnt_d    = '0;
            frame_count_d = '0;
            drop_count_d  = '0;
        end else begin
            if (push_s) begin
                if (last_s) begin
                    beat_cnt_d    = '0;
                    frame_count_d = frame_count_q + CntWidth'(1);
                end else begin
                    beat_cnt_d = beat_cnt_q + BeatW'(1);
                end
            end else begin
                beat_cnt_d = beat_cnt_q;
            end
            if (drop_s && (drop_count_q != {CntWidth{1'b1}})) begin
                drop_count_d = drop_count_q + CntWidth'(1);
            end else begin
                drop_count_d = drop_count_q;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (frame_done_s && (NUM_FRAMES != 0) &&
                    (frame_count_d == CntWidth'(NUM_FRAMES))) begin
                    state_d = ST_FLUSH;
                end else if (stop) begin
                    // Use the post-push beat count so a sample accepted in the
                    // same cycle as stop still gets a complete frame.
                    if (beat_cnt_d == '0) begin
                        state_d = ST_FLUSH;
                    end else begin
                        state_d = ST_STOP_PEND;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_STOP_PEND: begin
                if (frame_done_s) begin
                    state_d = ST_FLUSH;
                end else begin
                    state_d = ST_STOP_PEND;
                end
            end
            ST_FLUSH: begin
                if (count_q == 2'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_FLUSH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Two-entry buffer: head feeds the output, tail only fills when head is busy.
    always_comb begin
        head_data_d = head_data_q;
        head_last_d = head_last_q;
        tail_data_d = tail_data_q;
        tail_last_d = tail_last_q;
        count_d     = count_q;
        case (count_q)
            2'd0: begin
                if (push_s) begin
                    head_data_d = clamped_s;
                    head_last_d = last_s;
                    count_d     = 2'd1;
                end else begin
                    count_d = 2'd0;
                end
            end
            2'd1: begin
                if (push_s && pop_s) begin
                    head_data_d = clamped_s;
                    head_last_d = last_s;
                end else if (push_s) begin
                    tail_data_d = clamped_s;
                    tail_last_d = last_s;
                    count_d     = 2'd2;
                end else if (pop_s) begin
                    // Clear the stale flag so m_last never shows without m_valid.
                    head_last_d = 1'b0;
                    count_d     = 2'd0;
                end else begin
                    count_d = 2'd1;
                end
            end
            2'd2: begin
                if (pop_s) begin
                    head_data_d = tail_data_q;
                    head_last_d = tail_last_q;
                    count_d     = 2'd1;
                end else begin
                    count_d = 2'd2;
                end
            end
            default: begin
                head_last_d = 1'b0;
                count_d     = 2'd0;
            end
        endcase
    end

    assign m_data      = head_data_q;
    assign m_last      = head_last_q;
    assign m_valid     = m_valid_q;
    assign busy        = busy_q;
    assign drop_count  = drop_count_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_axis_sample_framer.sv
// -----------------------------------------------------------------------------
// Testbench for axis_sample_framer. Directed sequences plus a randomized phase.
// A queue-based reference model follows the main instance every cycle. A second
// instance with NUM_FRAMES=2 covers the auto-stop case.
// -----------------------------------------------------------------------------
module tb_axis_sample_framer;

    localparam int DW   = 16;
    localparam int MAXV = 2048;
    localparam int FL   = 8;
    localparam int CW   = 16;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PEND  = 2;
    localparam int M_FLUSH = 3;

    logic          clk      = 1'b0;
    logic          rst      = 1'b1;
    logic          start    = 1'b0;
    logic          stop     = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data  = '0;
    logic          m_ready  = 1'b0;

    logic [DW-1:0] m_data, m_data_af;
    logic          m_valid, m_valid_af;
    logic          m_last, m_last_af;
    logic          busy, busy_af;
    logic [CW-1:0] drop_count, drop_count_af;
    logic [CW-1:0] frame_count, frame_count_af;

    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;

    always #5 clk = ~clk;

    axis_sample_framer #(
        .DataWidth(DW), .MAX_VALUE(MAXV), .FRAME_LEN(FL), .NUM_FRAMES(0), .CntWidth(CW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .in_valid(in_valid), .in_data(in_data),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .busy(busy), .drop_count(drop_count), .frame_count(frame_count)
    );

    axis_sample_framer #(
        .DataWidth(DW), .MAX_VALUE(MAXV), .FRAME_LEN(FL), .NUM_FRAMES(2), .CntWidth(CW)
    ) dut_af (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .in_valid(in_valid), .in_data(in_data),
        .m_data(m_data_af), .m_valid(m_valid_af), .m_ready(m_ready), .m_last(m_last_af),
        .busy(busy_af), .drop_count(drop_count_af), .frame_count(frame_count_af)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    beat_t         mq[$];
    int            md_mode  = M_IDLE;
    int            m_beat   = 0;
    logic [CW-1:0] m_frames = '0;
    logic [CW-1:0] m_drops  = '0;

    function automatic logic [DW-1:0] mclamp(input logic [DW-1:0] x);
        int v;
        v = int'($signed(x));
        if (v < -MAXV) v = -MAXV;
        else if (v > MAXV - 1) v = MAXV - 1;
        return DW'(v);
    endfunction

    task automatic model_step();
        int   sz0;
        int   mode0;
        logic acc;
        logic lastf;
        acc   = 1'b0;
        lastf = 1'b0;
        if (rst) begin
            mq.delete();
            md_mode  = M_IDLE;
            m_beat   = 0;
            m_frames = '0;
            m_drops  = '0;
        end else begin
            sz0   = mq.size();
            mode0 = md_mode;
            if (mode0 == M_IDLE && start) begin
                md_mode  = M_RUN;
                m_beat   = 0;
                m_frames = '0;
                m_drops  = '0;
            end
            if ((mode0 == M_RUN || mode0 == M_PEND) && in_valid) begin
                if (sz0 < 2) begin
                    acc    = 1'b1;
                    lastf  = (m_beat == FL - 1);
                    m_beat = lastf ? 0 : m_beat + 1;
                    if (lastf) m_frames = m_frames + 1'b1;
                end else if (m_drops != {CW{1'b1}}) begin
                    m_drops = m_drops + 1'b1;
                end
            end
            if (sz0 != 0 && m_ready) void'(mq.pop_front());
            if (acc) mq.push_back('{d: mclamp(in_data), l: lastf});
            if (mode0 == M_RUN && stop) md_mode = (m_beat == 0) ? M_FLUSH : M_PEND;
            if (mode0 == M_PEND && acc && lastf) md_mode = M_FLUSH;
            if (mode0 == M_FLUSH && sz0 == 0) md_mode = M_IDLE;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Compare the main instance against the model mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("mon_valid", m_valid, mq.size() != 0);
                if (mq.size() != 0) chk("mon_data", m_data, mq[0].d);
                chk("mon_last", m_last, (mq.size() != 0) ? mq[0].l : 1'b0);
                chk("mon_busy", busy, md_mode != M_IDLE);
                chk("mon_drop", drop_count, m_drops);
                chk("mon_frames", frame_count, m_frames);
            end
        end
    end

    // ---------------- clamp vector table ----------------
    typedef struct {
        logic [DW-1:0] din;
        logic [DW-1:0] dexp;
        logic          lexp;
    } vec_t;

    vec_t ctab[8];
    int   beats_af;
    logic [DW-1:0] lastd_af;
    logic          lastl_af;

    initial begin
        ctab[0] = '{16'h7FFF, 16'h07FF, 1'b0};
        ctab[1] = '{16'h8000, 16'hF800, 1'b0};
        ctab[2] = '{16'h07FF, 16'h07FF, 1'b0};
        ctab[3] = '{16'hF800, 16'hF800, 1'b0};
        ctab[4] = '{16'h0800, 16'h07FF, 1'b0};
        ctab[5] = '{16'hF7FF, 16'hF800, 1'b0};
        ctab[6] = '{16'h0000, 16'h0000, 1'b0};
        ctab[7] = '{16'hFFFF, 16'hFFFF, 1'b1};

        // Reset state
        repeat (3) tick();
        rst    = 1'b0;
        mon_en = 1'b1;
        chk("rst_valid", m_valid, 1'b0);
        chk("rst_last", m_last, 1'b0);
        chk("rst_data", m_data, 16'h0000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_drop", drop_count, 16'h0000);
        chk("rst_frames", frame_count, 16'h0000);

        // Basic framing, one-cycle latency
        m_ready = 1'b1;
        start   = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", busy, 1'b1);
        chk("start_noout", m_valid, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(i);
            tick();
            chk("basic_valid", m_valid, 1'b1);
            chk("basic_data", m_data, DW'(i));
            chk("basic_last", m_last, (i % 8) == 0);
        end
        in_valid = 1'b0;
        tick();
        chk("basic_frames", frame_count, 16'd2);
        chk("basic_drop", drop_count, 16'd0);
        chk("basic_drained", m_valid, 1'b0);

        // Clamp table: exactly one frame
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = ctab[i].din;
            tick();
            chk("clamp_data", m_data, ctab[i].dexp);
            chk("clamp_last", m_last, ctab[i].lexp);
        end
        in_valid = 1'b0;
        tick();

        // Backpressure and drop
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(10 + i);
            tick();
            chk("bp_valid", m_valid, 1'b1);
            chk("bp_hold", m_data, 16'd10);
        end
        in_valid = 1'b0;
        chk("bp_drops", drop_count, 16'd3);
        m_ready = 1'b1;
        tick();
        chk("bp_second", m_data, 16'd11);
        chk("bp_second_v", m_valid, 1'b1);
        tick();
        chk("bp_empty", m_valid, 1'b0);
        // two beats already in this frame, so the 6th new sample closes it
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(20 + i);
            tick();
            chk("bp_frame_last", m_last, i == 5);
        end
        in_valid = 1'b0;
        tick();
        chk("bp_frames", frame_count, 16'd4);

        // Stop mid-frame
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(100 + i);
            tick();
        end
        in_valid = 1'b0;
        stop     = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_busy", busy, 1'b1);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(103 + i);
            tick();
            chk("stop_data", m_data, DW'(103 + i));
            chk("stop_last", m_last, i == 4);
        end
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1;
            in_data  = 16'd999;
            tick();
            chk("flush_quiet", m_valid, 1'b0);
            if (!busy) break;
        end
        chk("stop_idle", busy, 1'b0);
        repeat (2) begin
            tick();
            chk("idle_quiet", m_valid, 1'b0);
        end
        in_valid = 1'b0;
        chk("stop_frames", frame_count, 16'd5);

        // Auto-stop on the NUM_FRAMES=2 instance
        rst = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b1;
        tick();
        start    = 1'b0;
        beats_af = 0;
        lastd_af = '0;
        lastl_af = 1'b0;
        for (int i = 0; i < 24; i++) begin
            in_valid = (i < 20);
            in_data  = DW'(200 + i);
            tick();
            if (m_valid_af) begin
                beats_af++;
                lastd_af = m_data_af;
                lastl_af = m_last_af;
            end
        end
        in_valid = 1'b0;
        chk("af_beats", beats_af, 32'd16);
        chk("af_last_data", lastd_af, 16'd215);
        chk("af_last_flag", lastl_af, 1'b1);
        chk("af_frames", frame_count_af, 16'd2);
        chk("af_idle", busy_af, 1'b0);
        chk("af_drops", drop_count_af, 16'd0);

        // Reset mid-run with two beats buffered
        m_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(300 + i);
            tick();
        end
        in_valid = 1'b0;
        chk("mr_buffered", m_valid, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_valid", m_valid, 1'b0);
        chk("mr_busy", busy, 1'b0);
        chk("mr_frames", frame_count, 16'd0);
        chk("mr_drop", drop_count, 16'd0);
        start = 1'b1;
        tick();
        start   = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(400 + i);
            tick();
            chk("mr_data", m_data, DW'(400 + i));
            chk("mr_last", m_last, i == 7);
        end
        in_valid = 1'b0;

        // Randomized phase against the model
        for (int c = 0; c < 4000; c++) begin
            rst      = ($urandom_range(0, 299) == 0);
            start    = ($urandom_range(0, 29) == 0);
            stop     = ($urandom_range(0, 24) == 0);
            in_valid = ($urandom_range(0, 9) < 7);
            case ($urandom_range(0, 2))
                0:       in_data = DW'($urandom);
                1:       in_data = DW'($urandom_range(0, 8191)) - 16'd4096;
                default: in_data = DW'($urandom_range(2040, 2056));
            endcase
            m_ready = ($urandom_range(0, 9) < 6);
            tick();
        end
        rst      = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        in_valid = 1'b0;
        m_ready  = 1'b1;
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
